// File: rtl/bsg_one_hot_rotate_accum.sv
// One-hot position accumulator: each accepted increment rotates the pointer
// and loads a single-entry output register with the new position.
module bsg_one_hot_rotate_accum #(
    parameter int unsigned width_p          = 4,
    parameter int unsigned wrap_cnt_width_p = 8,
    localparam int unsigned bin_width_lp    = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clear_i,
    input  logic                        v_i,
    input  logic [width_p-1:0]          inc_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [width_p-1:0]          pos_o,
    output logic [bin_width_lp-1:0]     pos_bin_o,
    output logic                        wrap_o,
    input  logic                        yumi_i,
    output logic [wrap_cnt_width_p-1:0] wrap_cnt_o
);

    logic [width_p-1:0]          pos_r;
    logic [width_p-1:0]          pos_n;
    logic [bin_width_lp-1:0]     pos_bin_r;
    logic [bin_width_lp-1:0]     pos_bin_n;
    logic                        v_r;
    logic                        wrap_r;
    logic                        wrap_n;
    logic [width_p-1:0]          wrap_terms;
    logic [wrap_cnt_width_p-1:0] wrap_cnt_r;
    logic                        accept;

    assign ready_o = ~reset_i & ~clear_i & (~v_r | yumi_i);
    assign accept  = v_i & ready_o;

    // One-hot add as a rotation: new bit j is set when pos bit (j-k) meets inc bit k.
    for (genvar j = 0; j < width_p; j++) begin : g_rot
        logic [width_p-1:0] terms;
        for (genvar k = 0; k < width_p; k++) begin : g_term
            localparam int unsigned src_lp = (j + width_p - k) % width_p;
            assign terms[k] = pos_r[src_lp] & inc_i[k];
        end
        assign pos_n[j] = |terms;
    end

    // Position p wraps for any increment k with p + k >= width_p.
    assign wrap_terms[0] = 1'b0;
    for (genvar p = 1; p < width_p; p++) begin : g_wrap
        assign wrap_terms[p] = pos_r[p] & (|inc_i[width_p-1:width_p-p]);
    end
    assign wrap_n = |wrap_terms;

    for (genvar b = 0; b < bin_width_lp; b++) begin : g_bin
        logic [width_p-1:0] hits;
        for (genvar j = 0; j < width_p; j++) begin : g_hit
            if (((j >> b) & 1) == 1) begin : g_on
                assign hits[j] = pos_n[j];
            end else begin : g_off
                assign hits[j] = 1'b0;
            end
        end
        assign pos_bin_n[b] = |hits;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i | clear_i) begin
            pos_r      <= {{(width_p-1){1'b0}}, 1'b1};
            pos_bin_r  <= '0;
            v_r        <= 1'b0;
            wrap_r     <= 1'b0;
            wrap_cnt_r <= '0;
        end else if (accept) begin
            pos_r     <= pos_n;
            pos_bin_r <= pos_bin_n;
            wrap_r    <= wrap_n;
            v_r       <= 1'b1;
            if (wrap_n && (wrap_cnt_r != '1)) begin
                wrap_cnt_r <= wrap_cnt_r + {{(wrap_cnt_width_p-1){1'b0}}, 1'b1};
            end
        end else if (yumi_i) begin
            v_r <= 1'b0;
        end
    end

    assign v_o        = v_r;
    assign pos_o      = pos_r;
    assign pos_bin_o  = pos_bin_r;
    assign wrap_o     = wrap_r;
    assign wrap_cnt_o = wrap_cnt_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(v_i && !$onehot(inc_i)))
                else $error("inc_i is not one-hot while v_i is set");
            assert (!(yumi_i && !v_r))
                else $error("yumi_i asserted while v_o is low");
        end
    end
`endif

endmodule
